// File: rtl/pp_pkg.sv
// Shared defaults and write-FSM encoding for the ping-pong frame sink.
package pp_pkg;

   localparam int DATA_W_DEF    = 64;
   localparam int FRAME_LEN_DEF = 64;
   localparam int ADDR_W_DEF    = 6;

   // Write-side FSM encoding
   localparam logic W_FILL = 1'b0;
   localparam logic W_WAIT = 1'b1;

endpackage

// File: rtl/pp_rd_pipe.sv
// Two-stage read-latency pipeline. Stage 1 covers the external RAM's
// one-cycle read latency (valid and bank select). Stage 2 registers the
// selected bank's data. The output data holds between responses.
module pp_rd_pipe
   import pp_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk_50m,
   input  logic              rst_n,
   input  logic              req,
   input  logic              bank,
   input  logic [DATA_W-1:0] ram1_rd_data,
   input  logic [DATA_W-1:0] ram2_rd_data,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data
);

   logic s1_valid;
   logic s1_bank;

   // Advance valid/bank through both stages and capture data from the bank that was addressed
   // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_bank  <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         s1_valid <= req;
         s1_bank  <= bank;
         rd_valid <= s1_valid;
         if (s1_valid) begin
            rd_data <= s1_bank ? ram2_rd_data : ram1_rd_data;
         end
      end
   end

endmodule

// File: rtl/pp_frame_sink.sv
// Ping-pong frame sink. It writes incoming words into one of two external
// RAM banks. It presents completed frames for random-access reads and
// stalls upstream while both banks hold unreleased frames.
module pp_frame_sink
   import pp_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int FRAME_LEN = FRAME_LEN_DEF,
   parameter int ADDR_W    = ADDR_W_DEF
) (
   input  logic              clk_50m,
   input  logic              rst_n,
   input  logic              i_data_valid,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_ready,
   output logic              ram1_wr_en,
   output logic              ram2_wr_en,
   output logic [ADDR_W-1:0] ram1_wr_addr,
   output logic [ADDR_W-1:0] ram2_wr_addr,
   output logic [DATA_W-1:0] ram1_wr_data,
   output logic [DATA_W-1:0] ram2_wr_data,
   output logic [ADDR_W-1:0] ram1_rd_addr,
   output logic [ADDR_W-1:0] ram2_rd_addr,
   input  logic [DATA_W-1:0] ram1_rd_data,
   input  logic [DATA_W-1:0] ram2_rd_data,
   output logic              o_frame_rdy,
   output logic              o_frame_bank,
   input  logic              i_rd_req,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic              o_rd_valid,
   output logic [DATA_W-1:0] o_rd_data,
   input  logic              i_frame_release,
   output logic [15:0]       o_frame_cnt
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

   logic              state;
   logic              state_nxt;
   logic              wr_bank;
   logic              rd_bank;
   logic [1:0]        full;
   logic [1:0]        full_nxt;
   logic [ADDR_W-1:0] wr_idx;
   logic              transfer;
   logic              frame_done;
   logic              release_ok;
   logic              rd_accept;

   // Handshake, frame completion, release qualification and next full flags / FSM state
   // NOTE: every signal gets a default before any branch, so no latch can be inferred.
   always_comb begin
      o_ready    = rst_n && (state == W_FILL);
      transfer   = i_data_valid && o_ready;
      frame_done = transfer && (wr_idx == LAST_IDX);
      release_ok = i_frame_release && full[rd_bank];

      // A completion and a release always target different banks, so both can apply
      full_nxt = full;
      if (frame_done) full_nxt[wr_bank] = 1'b1;
      if (release_ok) full_nxt[rd_bank] = 1'b0;

      state_nxt = state;
      case (state)
         W_FILL:  if (frame_done && full_nxt[!wr_bank]) state_nxt = W_WAIT;
         W_WAIT:  if (!full[wr_bank]) state_nxt = W_FILL;
         default: state_nxt = W_FILL;
      endcase
   end

   // Bank write strobes and read address steering
   always_comb begin
      ram1_wr_en   = transfer && !wr_bank;
      ram2_wr_en   = transfer &&  wr_bank;
      ram1_wr_addr = wr_idx;
      ram2_wr_addr = wr_idx;
      ram1_wr_data = i_data;
      ram2_wr_data = i_data;

      rd_accept    = i_rd_req && o_frame_rdy;
      ram1_rd_addr = (rd_accept && !rd_bank) ? i_rd_addr : '0;
      ram2_rd_addr = (rd_accept &&  rd_bank) ? i_rd_addr : '0;

      o_frame_rdy  = full[rd_bank];
      o_frame_bank = rd_bank;
   end

   // Write index, bank ping-pong, full flags, frame counter and read-bank rotation
   always_ff @(posedge clk_50m) begin
      if (!rst_n) begin
         state       <= W_FILL;
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b0;
         full        <= 2'b00;
         wr_idx      <= '0;
         o_frame_cnt <= '0;
      end else begin
         state <= state_nxt;
         full  <= full_nxt;
         if (transfer) begin
            if (frame_done) begin
               wr_idx      <= '0;
               wr_bank     <= ~wr_bank;
               o_frame_cnt <= o_frame_cnt + 16'd1;
            end else begin
               wr_idx <= wr_idx + 1'b1;
            end
         end
         if (release_ok) begin
            rd_bank <= ~rd_bank;
         end
      end
   end

   pp_rd_pipe #(
      .DATA_W (DATA_W)
   ) u_rd_pipe (
      .clk_50m      (clk_50m),
      .rst_n        (rst_n),
      .req          (rd_accept),
      .bank         (rd_bank),
      .ram1_rd_data (ram1_rd_data),
      .ram2_rd_data (ram2_rd_data),
      .rd_valid     (o_rd_valid),
      .rd_data      (o_rd_data)
   );

endmodule

// File: tb/tb_pp_frame_sink.sv
// Self-checking bench for pp_frame_sink. Two behavioural RAM banks with
// one-cycle read latency are attached. Read responses are checked by a
// scoreboard monitor against data value and arrival cycle.
module tb_pp_frame_sink;
   import pp_pkg::*;

   logic        clk_50m;
   logic        rst_n;
   logic        i_data_valid;
   logic [63:0] i_data;
   logic        o_ready;
   logic        ram1_wr_en, ram2_wr_en;
   logic [5:0]  ram1_wr_addr, ram2_wr_addr;
   logic [63:0] ram1_wr_data, ram2_wr_data;
   logic [5:0]  ram1_rd_addr, ram2_rd_addr;
   logic [63:0] ram1_rd_data, ram2_rd_data;
   logic        o_frame_rdy;
   logic        o_frame_bank;
   logic        i_rd_req;
   logic [5:0]  i_rd_addr;
   logic        o_rd_valid;
   logic [63:0] o_rd_data;
   logic        i_frame_release;
   logic [15:0] o_frame_cnt;

   pp_frame_sink dut (
      .clk_50m         (clk_50m),
      .rst_n           (rst_n),
      .i_data_valid    (i_data_valid),
      .i_data          (i_data),
      .o_ready         (o_ready),
      .ram1_wr_en      (ram1_wr_en),
      .ram2_wr_en      (ram2_wr_en),
      .ram1_wr_addr    (ram1_wr_addr),
      .ram2_wr_addr    (ram2_wr_addr),
      .ram1_wr_data    (ram1_wr_data),
      .ram2_wr_data    (ram2_wr_data),
      .ram1_rd_addr    (ram1_rd_addr),
      .ram2_rd_addr    (ram2_rd_addr),
      .ram1_rd_data    (ram1_rd_data),
      .ram2_rd_data    (ram2_rd_data),
      .o_frame_rdy     (o_frame_rdy),
      .o_frame_bank    (o_frame_bank),
      .i_rd_req        (i_rd_req),
      .i_rd_addr       (i_rd_addr),
      .o_rd_valid      (o_rd_valid),
      .o_rd_data       (o_rd_data),
      .i_frame_release (i_frame_release),
      .o_frame_cnt     (o_frame_cnt)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int wr_cnt = 0;

   logic [63:0] mem1 [0:63];
   logic [63:0] mem2 [0:63];

   typedef struct {
      logic [63:0] data;
      int          due;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   initial clk_50m = 1'b0;
   always #10 clk_50m = ~clk_50m;

   always @(posedge clk_50m) cyc <= cyc + 1;

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem1[i] = '1;
         mem2[i] = '1;
      end
   end

   // Behavioural RAM banks: synchronous write, one-cycle registered read
   always @(posedge clk_50m) begin
      if (ram1_wr_en) mem1[ram1_wr_addr] <= ram1_wr_data;
      if (ram2_wr_en) mem2[ram2_wr_addr] <= ram2_wr_data;
      wr_cnt       <= wr_cnt + int'(ram1_wr_en) + int'(ram2_wr_en);
      ram1_rd_data <= mem1[ram1_rd_addr];
      ram2_rd_data <= mem2[ram2_rd_addr];
   end

   // Scoreboard monitor: every read response must match the oldest pending expectation
   always @(negedge clk_50m) begin
      if (o_rd_valid) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected actual=%0d required=no response", o_rd_data);
         end else begin
            mon_e = sb_q.pop_front();
            if (o_rd_data !== mon_e.data || cyc != mon_e.due) begin
               errors++;
               $display("FAIL rd_resp actual=%0d@cyc%0d required=%0d@cyc%0d",
                        o_rd_data, cyc, mon_e.data, mon_e.due);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk_50m);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic send_words(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         i_data_valid = 1'b1;
         i_data       = 64'(base + i);
         tick();
      end
      i_data_valid = 1'b0;
   endtask

   task automatic rd(input logic [5:0] addr, input int exp_val);
      i_rd_req  = 1'b1;
      i_rd_addr = addr;
      sb_q.push_back('{data: 64'(exp_val), due: cyc + 2});
      tick();
      i_rd_req  = 1'b0;
   endtask

   initial begin
      rst_n           = 1'b0;
      i_data_valid    = 1'b0;
      i_data          = '0;
      i_rd_req        = 1'b0;
      i_rd_addr       = '0;
      i_frame_release = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Reset state
      check("rst_ready",      64'(o_ready),      64'd1);
      check("rst_frame_rdy",  64'(o_frame_rdy),  64'd0);
      check("rst_frame_bank", 64'(o_frame_bank), 64'd0);
      check("rst_frame_cnt",  64'(o_frame_cnt),  64'd0);
      check("rst_rd_valid",   64'(o_rd_valid),   64'd0);
      check("rst_rd_data",    o_rd_data,         64'd0);

      // Read request with no readable frame produces nothing
      i_rd_req  = 1'b1;
      i_rd_addr = 6'd3;
      tick();
      i_rd_req  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("norm_rd_valid", 64'(o_rd_valid), 64'd0);
         tick();
      end

      // First frame: words 0..63 into bank 0
      send_words(0, 64);
      check("f1_frame_rdy",  64'(o_frame_rdy),  64'd1);
      check("f1_frame_bank", 64'(o_frame_bank), 64'd0);
      check("f1_frame_cnt",  64'(o_frame_cnt),  64'd1);
      check("f1_ready",      64'(o_ready),      64'd1);
      check("f1_mem1_0",     mem1[0],           64'd0);
      check("f1_mem1_63",    mem1[63],          64'd63);
      rd(6'd63, 63);
      repeat (4) tick();
      check("rd63_drained",  64'(sb_q.size()),  64'd0);
      check("rd63_hold",     o_rd_data,         64'd63);
      check("rd63_idle",     64'(o_rd_valid),   64'd0);

      // Second frame fills bank 1 with no release: sink stalls
      send_words(64, 64);
      check("f2_ready",      64'(o_ready),      64'd0);
      check("f2_state",      64'(dut.state),    64'(W_WAIT));
      check("f2_frame_cnt",  64'(o_frame_cnt),  64'd2);
      check("f2_frame_bank", 64'(o_frame_bank), 64'd0);
      check("f2_mem2_0",     mem2[0],           64'd64);
      check("f2_mem2_63",    mem2[63],          64'd127);
      i_data_valid = 1'b1;
      i_data       = 64'd999;
      repeat (2) tick();
      i_data_valid = 1'b0;
      check("stall_wr_cnt",  64'(wr_cnt),       64'd128);
      check("stall_mem1_0",  mem1[0],           64'd0);
      check("stall_ready",   64'(o_ready),      64'd0);

      // Release while stalled
      i_frame_release = 1'b1;
      tick();
      i_frame_release = 1'b0;
      check("rel_frame_bank", 64'(o_frame_bank), 64'd1);
      check("rel_frame_rdy",  64'(o_frame_rdy),  64'd1);
      check("rel_ready_1",    64'(o_ready),      64'd0);
      tick();
      check("rel_ready_2",    64'(o_ready),      64'd1);
      check("rel_state",      64'(dut.state),    64'(W_FILL));

      // Reset after 30 words of a partial frame
      send_words(200, 30);
      check("part_wr_cnt", 64'(wr_cnt), 64'd158);
      rst_n        = 1'b0;
      i_data_valid = 1'b1;
      i_data       = 64'hdead;
      repeat (2) tick();
      check("mrst_wr_cnt",     64'(wr_cnt),       64'd158);
      check("mrst_frame_rdy",  64'(o_frame_rdy),  64'd0);
      check("mrst_frame_bank", 64'(o_frame_bank), 64'd0);
      check("mrst_frame_cnt",  64'(o_frame_cnt),  64'd0);
      check("mrst_rd_valid",   64'(o_rd_valid),   64'd0);
      check("mrst_rd_data",    o_rd_data,         64'd0);
      i_data_valid = 1'b0;
      rst_n        = 1'b1;
      tick();
      check("mrst_ready",      64'(o_ready),      64'd1);
      check("mrst_state",      64'(dut.state),    64'(W_FILL));
      send_words(0, 64);
      for (int i = 0; i < 64; i++) begin
         check($sformatf("f3_mem1_%0d", i), mem1[i], 64'(i));
      end
      check("f3_wr_cnt",     64'(wr_cnt),       64'd222);
      check("f3_frame_rdy",  64'(o_frame_rdy),  64'd1);
      check("f3_frame_bank", 64'(o_frame_bank), 64'd0);
      check("f3_frame_cnt",  64'(o_frame_cnt),  64'd1);

      // Read and release in the same cycle: data comes from the released bank
      i_rd_req        = 1'b1;
      i_rd_addr       = 6'd5;
      i_frame_release = 1'b1;
      sb_q.push_back('{data: 64'd5, due: cyc + 2});
      tick();
      i_rd_req        = 1'b0;
      i_frame_release = 1'b0;
      check("rr_frame_bank", 64'(o_frame_bank), 64'd1);
      check("rr_frame_rdy",  64'(o_frame_rdy),  64'd0);
      repeat (3) tick();
      check("rr_drained",    64'(sb_q.size()),  64'd0);
      check("rr_hold",       o_rd_data,         64'd5);

      // Next frame lands in bank 1 and becomes the readable frame
      send_words(300, 64);
      check("f4_frame_rdy",  64'(o_frame_rdy),  64'd1);
      check("f4_frame_bank", 64'(o_frame_bank), 64'd1);
      check("f4_frame_cnt",  64'(o_frame_cnt),  64'd2);
      check("f4_mem2_5",     mem2[5],           64'd305);
      rd(6'd10, 310);
      repeat (4) tick();
      check("f4_drained",    64'(sb_q.size()),  64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pp_frame_sink.md
PP_FRAME_SINK -- requirements
Module: pp_frame_sink

Interface
REQ-001 SHALL use parameters: DATA_W, default 64, word width; FRAME_LEN, default 64, words per frame; ADDR_W, default 6, bank address width.
REQ-002 Port clk_50m: input, 1 bit, sole clock; all logic on rising edge.
REQ-003 Port rst_n: input, 1 bit, reset, synchronous, active-low.
REQ-004 Port i_data_valid: input, 1 bit, upstream word valid.
REQ-005 Port i_data: input, DATA_W bits, upstream word.
REQ-006 Port o_ready: output, 1 bit, sink can accept a word this cycle.
REQ-007 Ports ram1_wr_en / ram2_wr_en: output, 1 bit each, bank write strobes.
REQ-008 Ports ram1_wr_addr / ram2_wr_addr: output, ADDR_W bits each, bank write addresses.
REQ-009 Ports ram1_wr_data / ram2_wr_data: output, DATA_W bits each, bank write data.
REQ-010 Ports ram1_rd_addr / ram2_rd_addr: output, ADDR_W bits each, bank read addresses.
REQ-011 Ports ram1_rd_data / ram2_rd_data: input, DATA_W bits each, bank read data; external RAM has 1-cycle read latency.
REQ-012 Port o_frame_rdy: output, 1 bit, a complete frame is readable.
REQ-013 Port o_frame_bank: output, 1 bit, bank holding the readable frame (0 = ram1, 1 = ram2).
REQ-014 Ports i_rd_req / i_rd_addr: input, 1 bit / ADDR_W bits, random-access read request.
REQ-015 Ports o_rd_valid / o_rd_data: output, 1 bit / DATA_W bits, read response.
REQ-016 Port i_frame_release: input, 1 bit, consumer frees the readable bank.
REQ-017 Port o_frame_cnt: output, 16 bits, count of completed frames, wraps.

Function
REQ-018 Word transfer SHALL occur on any cycle with i_data_valid=1 and o_ready=1; it writes i_data combinationally to the current write bank at the current word index.
REQ-019 Write FSM SHALL have states W_FILL and W_WAIT; o_ready=1 only in W_FILL; ram*_wr_en SHALL be high only on a transfer cycle.
REQ-020 The word index SHALL increment per transfer; on the transfer at index FRAME_LEN-1 it returns to 0, the bank's full flag is set, wr_bank toggles, and o_frame_cnt increments.
REQ-021 W_FILL SHALL go to W_WAIT when the newly selected wr_bank is full; W_WAIT SHALL return to W_FILL on the cycle after that bank's flag clears.
REQ-022 o_frame_rdy SHALL equal the full flag of rd_bank; o_frame_bank SHALL equal rd_bank.
REQ-023 i_frame_release with o_frame_rdy=1 SHALL clear the rd_bank full flag and toggle rd_bank; with o_frame_rdy=0 it SHALL be ignored.
REQ-024 A frame completing on one bank and a release on the other bank in the same cycle SHALL both take effect.
REQ-025 i_rd_req with o_frame_rdy=1 SHALL drive i_rd_addr onto the rd_bank read address; o_rd_valid and o_rd_data SHALL be registered 2 cycles after the request.
REQ-026 i_rd_req with o_frame_rdy=0 SHALL produce no o_rd_valid.
REQ-027 A read accepted in the same cycle as a release SHALL still return data from the released bank.
REQ-028 o_rd_data SHALL hold its last value when o_rd_valid=0.

Reset
REQ-029 While rst_n=0 at a clock edge: state W_FILL, wr_bank=0, rd_bank=0, both full flags clear, word index 0, o_frame_cnt=0, o_rd_valid=0, o_rd_data=0, read pipeline flushed.
REQ-030 Reset mid-frame SHALL discard partial and full frames with no further RAM writes; o_ready SHALL be 1 on the first cycle after deassertion.

Structure
REQ-031 DATA_W, FRAME_LEN, ADDR_W defaults and the write-FSM state encoding SHALL reside in shared package pp_pkg.
REQ-032 The read-latency pipeline SHALL be sub-module pp_rd_pipe, carrying valid, bank select and data across 2 stages.

Verification
REQ-033 The bench SHALL cover 64 back-to-back words 0..63: o_frame_rdy=1, o_frame_bank=0, o_frame_cnt=1 one cycle after the last word; a read at addr 63 returns 63 two cycles later.
REQ-034 The bench SHALL cover 128 words with no release: ready drops after word 127, state W_WAIT, and a 129th valid word is not written.
REQ-035 The bench SHALL cover a release while stalled: rd_bank becomes 1, and o_ready=1 two cycles after the release.
REQ-036 The bench SHALL cover i_rd_req and i_frame_release in the same cycle at addr 5 (value 5): o_rd_valid returns 5, and the next frame_rdy refers to bank 1.
REQ-037 The bench SHALL cover rst_n=0 asserted after 30 words: all outputs are at reset values, and the next 64 words land in bank 0 at addresses 0..63.
REQ-038 The bench SHALL cover i_rd_req while o_frame_rdy=0: o_rd_valid stays 0 for 3 cycles.
